// File: rtl/bk_sub_pipe_pkg.sv
// Shared Brent-Kung definitions: default operand width, generate/propagate pair
// and the prefix combine cell used by the adder and its inverse subtractor.
package bk_pkg;

  localparam int WIDTH_DEF = 12;

  typedef logic [WIDTH_DEF:0]   sum_t;
  typedef logic [WIDTH_DEF-1:0] opa_t;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Combine a higher-order group with the adjacent lower-order group.
  function automatic gp_t bk_cell(input gp_t gp_hi, input gp_t gp_lo);
    gp_t r;
    r.g = gp_hi.g | (gp_hi.p & gp_lo.g);
    r.p = gp_hi.p & gp_lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_sub_pipe_stage.sv
// Generic valid/data register slice. A stage loads when empty or when the
// next stage loads, so bubbles collapse even while the output is stalled.
module bk_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_next_load,
  output logic         o_load,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_vld;
  logic [W-1:0] r_data;

  assign o_load  = !r_vld || i_next_load;
  assign o_valid = r_vld;
  assign o_data  = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (o_load) begin
      r_vld <= i_valid;
    end
  end

  // Payload only captures real items, so an idle slice keeps its last value.
  always_ff @(posedge clk) begin
    if (o_load && i_valid) begin
      r_data <= i_data;
    end
  end

endmodule

// File: rtl/bk_sub_pipe.sv
// Three-stage Brent-Kung prefix subtractor: recovers B = S - A from an adder
// sum S and one operand A, flagging underflow and non-representable B.
module bk_sub_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_opa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_diff,
  output logic             out_underflow,
  output logic             out_range_err
);

  localparam int N             = WIDTH + 1;
  localparam int PREFIX_LEVELS = $clog2(WIDTH + 1);
  localparam int UP_S2         = (PREFIX_LEVELS + 1) / 2;
  localparam int W1            = 2 * N;
  localparam int W2            = 3 * N;
  localparam int W3            = N + 2;

  // Clamps the partner index so dead branches of the unrolled sweeps stay in range.
  function automatic int src_idx(input int i, input int span);
    return (i >= span) ? (i - span) : 0;
  endfunction

  logic          w_ld_p1, w_ld_p2, w_ld_p3;
  logic          w_vld_p1, w_vld_p2, w_vld_p3;
  logic [W1-1:0] w_dat_p1;
  logic [W2-1:0] w_dat_p2;
  logic [W3-1:0] w_dat_p3;

  // ---- stage 1: per-bit generate/propagate of S + ~{0,A} with cin folded into bit 0
  logic [N-1:0] w_nb_p0;
  gp_t  [N-1:0] w_gp_p0;

  assign w_nb_p0 = ~{1'b0, in_opa};

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_gp_p0[i].g = in_sum[i] & w_nb_p0[i];
      w_gp_p0[i].p = in_sum[i] ^ w_nb_p0[i];
    end
    w_gp_p0[0].g = w_gp_p0[0].g | w_gp_p0[0].p;
  end

  bk_pipe_stage #(.W(W1)) u_stage1 (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (in_valid),
    .i_data      (w_gp_p0),
    .i_next_load (w_ld_p2),
    .o_load      (w_ld_p1),
    .o_valid     (w_vld_p1),
    .o_data      (w_dat_p1)
  );

  assign in_ready = w_ld_p1;

  // ---- stage 2: lower half of the up-sweep; raw propagate rides along for the final XOR
  gp_t  [N-1:0] w_gp_p1;
  gp_t  [N-1:0] w_up_p1;
  logic [N-1:0] w_p_p1;

  assign w_gp_p1 = w_dat_p1;

  always_comb begin
    w_up_p1 = w_gp_p1;
    for (int l = 1; l <= UP_S2; l++) begin
      for (int i = 0; i < N; i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          w_up_p1[i] = bk_cell(w_up_p1[i], w_up_p1[src_idx(i, 1 << (l - 1))]);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_p_p1[i] = w_gp_p1[i].p;
    end
  end

  bk_pipe_stage #(.W(W2)) u_stage2 (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (w_vld_p1),
    .i_data      ({w_p_p1, w_up_p1}),
    .i_next_load (w_ld_p3),
    .o_load      (w_ld_p2),
    .o_valid     (w_vld_p2),
    .o_data      (w_dat_p2)
  );

  // ---- stage 3: finish up-sweep, full down-sweep, sum bits and flags
  gp_t  [N-1:0] w_gp_p2;
  gp_t  [N-1:0] w_pre_p2;
  logic [N-1:0] w_p_p2;
  logic [N-1:0] w_diff_p2;
  logic         w_uf_p2;
  logic         w_re_p2;

  assign w_gp_p2 = w_dat_p2[W1-1:0];
  assign w_p_p2  = w_dat_p2[W2-1:W1];

  always_comb begin
    w_pre_p2 = w_gp_p2;
    for (int l = UP_S2 + 1; l <= PREFIX_LEVELS; l++) begin
      for (int i = 0; i < N; i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          w_pre_p2[i] = bk_cell(w_pre_p2[i], w_pre_p2[src_idx(i, 1 << (l - 1))]);
        end
      end
    end
    for (int l = PREFIX_LEVELS - 1; l >= 1; l--) begin
      for (int i = 0; i < N; i++) begin
        if ((i >= (1 << l)) && (((i + 1) % (1 << l)) == (1 << (l - 1)))) begin
          w_pre_p2[i] = bk_cell(w_pre_p2[i], w_pre_p2[src_idx(i, 1 << (l - 1))]);
        end
      end
    end
  end

  // w_pre_p2[i].g is the carry out of bit i; bit 0 sees the injected cin of 1.
  always_comb begin
    w_diff_p2[0] = ~w_p_p2[0];
    for (int i = 1; i < N; i++) begin
      w_diff_p2[i] = w_p_p2[i] ^ w_pre_p2[i-1].g;
    end
    w_uf_p2 = ~w_pre_p2[N-1].g;
    w_re_p2 = w_uf_p2 | w_diff_p2[N-1];
  end

  bk_pipe_stage #(.W(W3)) u_stage3 (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (w_vld_p2),
    .i_data      ({w_re_p2, w_uf_p2, w_diff_p2}),
    .i_next_load (out_ready),
    .o_load      (w_ld_p3),
    .o_valid     (w_vld_p3),
    .o_data      (w_dat_p3)
  );

  // Outputs read zero whenever no result is held, including straight after reset.
  assign out_valid     = w_vld_p3;
  assign out_diff      = w_vld_p3 ? w_dat_p3[N-1:0] : '0;
  assign out_underflow = w_vld_p3 & w_dat_p3[N];
  assign out_range_err = w_vld_p3 & w_dat_p3[N+1];

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Bench for bk_sub_pipe: directed corner cases, stall and mid-stream reset,
// then randomized traffic against an arithmetic reference scoreboard.
module tb_bk_sub_pipe;
  import bk_pkg::*;

  typedef struct packed {
    logic [12:0] s;
    logic [11:0] a;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  sum_t        in_sum;
  opa_t        in_opa;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_diff;
  logic        out_underflow;
  logic        out_range_err;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_out = 0;
  logic  s_rdy = 1'b0;
  logic  s_acc = 1'b0;

  always #5 clk = ~clk;

  bk_sub_pipe #(.WIDTH(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_opa        (in_opa),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_diff      (out_diff),
    .out_underflow (out_underflow),
    .out_range_err (out_range_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, result reduced modulo 2^13.
  function automatic logic [14:0] model(input item_t it);
    int          d;
    logic        uf;
    logic        re;
    logic [12:0] df;
    d  = int'(it.s) - int'(it.a);
    uf = (d < 0);
    if (d < 0) d = d + 8192;
    df = d[12:0];
    re = uf || (d >= 4096);
    return {re, uf, df};
  endfunction

  // One cycle: sample at the falling edge, score, then return 1 ns after the rising edge.
  task automatic tick();
    item_t       it;
    logic [14:0] e;
    @(negedge clk);
    s_rdy = in_ready;
    s_acc = in_valid && in_ready;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("stale", 32'(out_valid), 32'(0));
      end else begin
        it = sb[0];
        e  = model(it);
        chk("diff", 32'(out_diff), 32'(e[12:0]));
        chk("uflow", 32'(out_underflow), 32'(e[13]));
        chk("rerr", 32'(out_range_err), 32'(e[14]));
        if (!out_range_err) chk("rtrip", 32'({1'b0, it.a} + {1'b0, out_diff[11:0]}), 32'(it.s));
        if (out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
    if (s_acc) sb.push_back({in_sum, in_opa});
    @(posedge clk);
    #1;
  endtask

  task automatic run_item(input string tag, input logic [12:0] s, input logic [11:0] a,
                          input logic [12:0] ed, input logic eu, input logic er);
    int lat;
    in_sum    = s;
    in_opa    = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk({tag, "_acc"}, 32'(s_acc), 32'(1));
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(3));
    chk({tag, "_diff"}, 32'(out_diff), 32'(ed));
    chk({tag, "_uf"}, 32'(out_underflow), 32'(eu));
    chk({tag, "_re"}, 32'(out_range_err), 32'(er));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t st[5];
    int    n_sent;
    int    n0;
    int    r;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_opa    = '0;
    out_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_diff", 32'(out_diff), 32'(0));
    chk("rst_uf", 32'(out_underflow), 32'(0));
    chk("rst_re", 32'(out_range_err), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'(1));

    run_item("single", 13'h0FFF, 12'h001, 13'h0FFE, 1'b0, 1'b0);
    run_item("under",  13'd5,    12'd9,   13'h1FFC, 1'b1, 1'b1);
    run_item("range",  13'h1FFF, 12'h000, 13'h1FFF, 1'b0, 1'b1);
    run_item("zero",   13'h0000, 12'h000, 13'h0000, 1'b0, 1'b0);
    run_item("wrap",   13'h0000, 12'hFFF, 13'h1001, 1'b1, 1'b1);

    // Back-to-back with the consumer stalled for five cycles.
    for (int k = 0; k < 5; k++) st[k] = {13'(100 + 37 * k), 12'(3 * k + 1)};
    n_sent = 0;
    n0     = n_out;
    for (int k = 0; k < 12; k++) begin
      in_valid = (n_sent < 5);
      if (n_sent < 5) {in_sum, in_opa} = st[n_sent];
      out_ready = !(k >= 2 && k <= 6);
      tick();
      if (k >= 3 && k <= 6) begin
        chk("stall_ready", 32'(s_rdy), 32'(0));
        chk("stall_sent", 32'(n_sent), 32'(3));
      end
      if (s_acc) n_sent++;
    end
    in_valid = 1'b0;
    chk("stall_out", 32'(n_out - n0), 32'(5));
    chk("stall_left", 32'(sb.size()), 32'(0));

    // Reset between edges with three items in flight.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_sum   = 13'($urandom);
      in_opa   = 12'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_full", 32'(out_valid), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", 32'(out_valid), 32'(0));
    chk("mid_diff", 32'(out_diff), 32'(0));
    chk("mid_uf", 32'(out_underflow), 32'(0));
    chk("mid_re", 32'(out_range_err), 32'(0));
    sb.delete();
    #2 rst = 1'b0;
    repeat (5) tick();
    chk("mid_ready", 32'(s_rdy), 32'(1));
    run_item("after_rst", 13'd100, 12'd58, 13'd42, 1'b0, 1'b0);

    // Random traffic; an offered item is held until accepted.
    for (int c = 0; c < 10000; c++) begin
      if (!(in_valid && !s_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 7));
        in_sum = (r == 0) ? 13'h0000 : (r == 1) ? 13'h1FFF : 13'($urandom);
        r = int'($urandom_range(0, 7));
        in_opa = (r == 0) ? 12'h000 : (r == 1) ? 12'hFFF : 12'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) tick();
    chk("drain", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
